// File: rtl/regfile_bypass_sb_pkg.sv
// Shared definitions for the bypassing register file: FSM state encoding and
// the index-width helper used to size address ports.
package regfile_bypass_sb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Address width for a register count; a single register still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_bypass_sb_scoreboard.sv
// Pending-writeback scoreboard: one bit per register, set by reservations,
// cleared by writebacks, looked up per read port.
module regfile_scoreboard
    import regfile_bypass_sb_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    parameter int AW    = idx_width(NREGS)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               set_en,
    input  logic [AW-1:0]      set_idx,
    input  logic               clr_en,
    input  logic [AW-1:0]      clr_idx,
    input  logic [NREAD*AW-1:0] rs,
    output logic [NREAD-1:0]   pending
);

    logic [NREGS-1:0] sb;
    logic [NREGS-1:0] sb_next;

    // Clear first, then set, so a same-cycle reserve of the written register wins.
    always_comb begin
        sb_next = sb;
        if (clr_en) begin
            sb_next[clr_idx] = 1'b0;
        end
        if (set_en) begin
            sb_next[set_idx] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_lookup
        logic [AW-1:0] rs_i;
        assign rs_i       = rs[i*AW +: AW];
        assign pending[i] = sb[rs_i] & ~(clr_en & (clr_idx == rs_i));
    end

endmodule

// File: rtl/regfile_bypass_sb.sv
// Multi-port register file with same-cycle write bypass, a pending-writeback
// scoreboard and a post-reset initialisation walk over the whole array.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_INIT | walking cnt over the array writing init values; ports quiet
//   ST_RUN  | array usable; reads, writes, bypass and reservations active
module regfile_bypass_sb
    import regfile_bypass_sb_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int NREGS     = 32,
    parameter int NREAD     = 2,
    parameter int INIT_MODE = 1,
    localparam int AW       = idx_width(NREGS)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NREAD*AW-1:0]   RS,
    output logic [NREAD*XLEN-1:0] ReadData,
    input  logic                  RegWrite,
    input  logic [AW-1:0]         RD,
    input  logic [XLEN-1:0]       WriteData,
    input  logic                  ResValid,
    input  logic [AW-1:0]         ResRD,
    output logic [NREAD-1:0]      Pending,
    output logic                  Ready
);

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [XLEN-1:0] regs [NREGS];

    logic            run;
    logic            wr_en;
    logic            res_en;
    logic [XLEN-1:0] init_val;
    logic [NREAD-1:0] sb_pending;

    // Reset also gates the ports combinationally so nothing leaks while it is held.
    assign run      = (state == ST_RUN) && !Reset;
    assign wr_en    = run && RegWrite && (RD != '0);
    assign res_en   = run && ResValid && (ResRD != '0);
    assign init_val = (INIT_MODE == 0) ? '0 : XLEN'(cnt);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_INIT;
            cnt   <= '0;
            Ready <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == AW'(NREGS - 1)) begin
                        state <= ST_RUN;
                        Ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                    Ready <= 1'b1;
                end
                default: begin
                    state <= ST_INIT;
                    cnt   <= '0;
                    Ready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (state == ST_INIT) begin
                regs[cnt] <= init_val;
            end else if (wr_en) begin
                regs[RD] <= WriteData;
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [AW-1:0]   rs_i;
        logic [XLEN-1:0] rdata_i;

        assign rs_i = RS[i*AW +: AW];

        always_comb begin
            rdata_i = '0;
            if (run && (rs_i != '0)) begin
                if (wr_en && (RD == rs_i)) begin
                    rdata_i = WriteData;
                end else begin
                    rdata_i = regs[rs_i];
                end
            end
        end

        assign ReadData[i*XLEN +: XLEN] = rdata_i;
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NREAD (NREAD),
        .AW    (AW)
    ) u_sb (
        .Clk     (Clk),
        .Reset   (Reset),
        .set_en  (res_en),
        .set_idx (ResRD),
        .clr_en  (wr_en),
        .clr_idx (RD),
        .rs      (RS),
        .pending (sb_pending)
    );

    assign Pending = run ? sb_pending : '0;

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: directed vector table, hand-written reset and
// init sequences, and randomized traffic checked against an array model.
module tb_regfile_bypass_sb;

    logic         Clk;
    logic         Reset;
    logic [9:0]   RS;
    logic [127:0] ReadData;
    logic         RegWrite;
    logic [4:0]   RD;
    logic [63:0]  WriteData;
    logic         ResValid;
    logic [4:0]   ResRD;
    logic [1:0]   Pending;
    logic         Ready;

    logic         Reset_b;
    logic [15:0]  RS_b;
    logic [127:0] ReadData_b;
    logic         RegWrite_b;
    logic [3:0]   RD_b;
    logic [31:0]  WriteData_b;
    logic         ResValid_b;
    logic [3:0]   ResRD_b;
    logic [3:0]   Pending_b;
    logic         Ready_b;

    regfile_bypass_sb dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .RS        (RS),
        .ReadData  (ReadData),
        .RegWrite  (RegWrite),
        .RD        (RD),
        .WriteData (WriteData),
        .ResValid  (ResValid),
        .ResRD     (ResRD),
        .Pending   (Pending),
        .Ready     (Ready)
    );

    regfile_bypass_sb #(
        .XLEN      (32),
        .NREGS     (16),
        .NREAD     (4),
        .INIT_MODE (0)
    ) dut_b (
        .Clk       (Clk),
        .Reset     (Reset_b),
        .RS        (RS_b),
        .ReadData  (ReadData_b),
        .RegWrite  (RegWrite_b),
        .RD        (RD_b),
        .WriteData (WriteData_b),
        .ResValid  (ResValid_b),
        .ResRD     (ResRD_b),
        .Pending   (Pending_b),
        .Ready     (Ready_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the default instance.
    bit              run_m;
    int              cyc_m;
    longint unsigned mem_m [32];
    bit              sb_m  [32];

    typedef struct {
        bit              rw;
        int              rd;
        longint unsigned wd;
        bit              rv;
        int              resrd;
        int              rs0;
        int              rs1;
        longint unsigned e0;
        longint unsigned e1;
        bit              p0;
        bit              p1;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rw, int rd, longint unsigned wd, bit rv, int resrd,
                                int rs0, int rs1, longint unsigned e0, longint unsigned e1,
                                bit p0, bit p1);
        vec_t v;
        v.rw = rw; v.rd = rd; v.wd = wd; v.rv = rv; v.resrd = resrd;
        v.rs0 = rs0; v.rs1 = rs1; v.e0 = e0; v.e1 = e1; v.p0 = p0; v.p1 = p1;
        return v;
    endfunction

    // Applies the architectural effect of one rising edge to the model.
    task automatic model_edge();
        if (Reset) begin
            run_m = 0;
            cyc_m = 0;
            foreach (sb_m[k]) sb_m[k] = 0;
        end else if (!run_m) begin
            cyc_m++;
            if (cyc_m == 32) begin
                run_m = 1;
                foreach (mem_m[k]) mem_m[k] = longint'(k);
            end
        end else begin
            if (RegWrite && RD != 0) begin
                mem_m[RD] = WriteData;
                sb_m[RD]  = 0;
            end
            if (ResValid && ResRD != 0) sb_m[ResRD] = 1;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit rw, input int rd, input longint unsigned wd,
                         input bit rv, input int resrd, input int rs0, input int rs1);
        RegWrite  = rw;
        RD        = 5'(rd);
        WriteData = wd;
        ResValid  = rv;
        ResRD     = 5'(resrd);
        RS        = {5'(rs1), 5'(rs0)};
    endtask

    task automatic check_model(input string nm);
        int rs;
        longint unsigned ed;
        bit ep;
        for (int p = 0; p < 2; p++) begin
            rs = (p == 0) ? int'(RS[4:0]) : int'(RS[9:5]);
            ed = 0;
            ep = 0;
            if (run_m && rs != 0) begin
                ed = (RegWrite && RD == 5'(rs)) ? WriteData : mem_m[rs];
                ep = sb_m[rs] && !(RegWrite && RD == 5'(rs));
            end
            check($sformatf("%s.data%0d", nm, p), ReadData[p*64 +: 64], ed);
            check($sformatf("%s.pend%0d", nm, p), 64'(Pending[p]), 64'(ep));
        end
        check($sformatf("%s.ready", nm), 64'(Ready), 64'(run_m));
    endtask

    task automatic wait_ready(input string nm, input int want);
        int n = 0;
        while (!Ready && n < 200) begin
            tick();
            n++;
        end
        check(nm, 64'(n), 64'(want));
    endtask

    initial begin
        int n;
        Reset = 1'b1;
        Reset_b = 1'b1;
        drive(0, 0, 0, 0, 0, 5, 31);
        RS_b = '0; RegWrite_b = 0; RD_b = '0; WriteData_b = '0; ResValid_b = 0; ResRD_b = '0;
        run_m = 0; cyc_m = 0;
        foreach (mem_m[k]) mem_m[k] = 0;
        foreach (sb_m[k]) sb_m[k] = 0;

        // Reset state and initialisation length.
        tick();
        check("rst.ready", 64'(Ready), 64'(0));
        check("rst.data0", ReadData[63:0], 64'h0);
        check("rst.pend", 64'(Pending), 64'(0));
        Reset = 1'b0;
        tick();
        check("init.data0", ReadData[63:0], 64'h0);
        check("init.data1", ReadData[127:64], 64'h0);
        wait_ready("init.len", 31);

        // Directed vector table, starting from the freshly initialised array.
        tbl[0]  = mk(0, 0,  0,       0, 0, 5, 31, 5,       31,      0, 0);
        tbl[1]  = mk(1, 7,  'hDEAD,  0, 0, 7, 0,  'hDEAD,  0,       0, 0);
        tbl[2]  = mk(0, 0,  0,       0, 0, 7, 7,  'hDEAD,  'hDEAD,  0, 0);
        tbl[3]  = mk(1, 0,  'hFFFF,  1, 0, 0, 0,  0,       0,       0, 0);
        tbl[4]  = mk(0, 0,  0,       0, 0, 0, 0,  0,       0,       0, 0);
        tbl[5]  = mk(0, 0,  0,       1, 9, 9, 9,  9,       9,       0, 0);
        tbl[6]  = mk(0, 0,  0,       0, 0, 9, 9,  9,       9,       1, 1);
        tbl[7]  = mk(1, 9,  'h1234,  0, 0, 8, 9,  8,       'h1234,  0, 0);
        tbl[8]  = mk(0, 0,  0,       0, 0, 9, 9,  'h1234,  'h1234,  0, 0);
        tbl[9]  = mk(1, 9,  'h55,    1, 9, 9, 9,  'h55,    'h55,    0, 0);
        tbl[10] = mk(0, 0,  0,       0, 0, 3, 9,  3,       'h55,    0, 1);
        tbl[11] = mk(0, 0,  0,       1, 3, 3, 9,  3,       'h55,    0, 1);
        tbl[12] = mk(1, 20, 'hABC,   0, 0, 3, 20, 3,       'hABC,   1, 0);
        tbl[13] = mk(0, 0,  0,       0, 0, 3, 9,  3,       'h55,    1, 1);
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rw, tbl[i].rd, tbl[i].wd, tbl[i].rv, tbl[i].resrd, tbl[i].rs0, tbl[i].rs1);
            #2;
            check($sformatf("tbl%0d.data0", i), ReadData[63:0], tbl[i].e0);
            check($sformatf("tbl%0d.data1", i), ReadData[127:64], tbl[i].e1);
            check($sformatf("tbl%0d.pend0", i), 64'(Pending[0]), 64'(tbl[i].p0));
            check($sformatf("tbl%0d.pend1", i), 64'(Pending[1]), 64'(tbl[i].p1));
            tick();
        end

        // Randomized traffic biased toward low registers so addresses collide.
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 1),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 31),
                  {$urandom, $urandom},
                  $urandom_range(0, 1),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 31),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 31),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 31));
            #2;
            check_model($sformatf("rnd%0d", c));
            tick();
        end

        // Reset while running re-initialises the array and clears reservations.
        drive(1, 12, 'h77, 1, 13, 12, 13);
        tick();
        drive(0, 0, 0, 0, 0, 12, 13);
        Reset = 1'b1;
        #2;
        check("rrun.held.data0", ReadData[63:0], 64'h0);
        check("rrun.held.pend", 64'(Pending), 64'(0));
        tick();
        Reset = 1'b0;
        check("rrun.ready", 64'(Ready), 64'(0));
        wait_ready("rrun.len", 32);
        #2;
        check_model("rrun.after");
        check("rrun.data0", ReadData[63:0], 64'd12);
        check("rrun.pend1", 64'(Pending[1]), 64'(0));

        // Reset pulsed mid-initialisation; writes and reserves during INIT are dropped.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        drive(1, 7, 'hBAD, 1, 4, 7, 4);
        for (int i = 0; i < 10; i++) tick();
        check("rinit.ready", 64'(Ready), 64'(0));
        check("rinit.quiet", ReadData[63:0], 64'h0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        wait_ready("rinit.len", 32);
        drive(0, 0, 0, 0, 0, 7, 4);
        #2;
        check("rinit.data0", ReadData[63:0], 64'd7);
        check("rinit.data1", ReadData[127:64], 64'd4);
        check("rinit.pend1", 64'(Pending[1]), 64'(0));

        // Four-port zero-initialised instance.
        tick();
        Reset_b = 1'b0;
        RS_b = {4'd15, 4'd10, 4'd5, 4'd1};
        n = 0;
        while (!Ready_b && n < 200) begin
            tick();
            n++;
        end
        check("b.len", 64'(n), 64'(16));
        for (int p = 0; p < 4; p++) check($sformatf("b.zero%0d", p), 64'(ReadData_b[p*32 +: 32]), 64'h0);
        RegWrite_b = 1; RD_b = 4'd3; WriteData_b = 32'hCAFEF00D; ResValid_b = 1; ResRD_b = 4'd3;
        RS_b = {4'd3, 4'd3, 4'd3, 4'd3};
        #2;
        for (int p = 0; p < 4; p++) begin
            check($sformatf("b.byp%0d", p), 64'(ReadData_b[p*32 +: 32]), 64'hCAFEF00D);
            check($sformatf("b.bpend%0d", p), 64'(Pending_b[p]), 64'(0));
        end
        tick();
        RegWrite_b = 0; ResValid_b = 0;
        #2;
        for (int p = 0; p < 4; p++) begin
            check($sformatf("b.hold%0d", p), 64'(ReadData_b[p*32 +: 32]), 64'hCAFEF00D);
            check($sformatf("b.hpend%0d", p), 64'(Pending_b[p]), 64'(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
